crypto_rsa: RTL and testbench

- RSA modular-exponentiation engine: ciphertext = plaintext^key mod n, on unsigned WIDTH-bit operands.
- Operands are captured with a load strobe; the computation is started with an encrypt strobe.
- Reports completion on ready and holds the result on ciphertext.
- Standalone leaf block, used as an encrypt/decrypt primitive: decrypt is the same operation with the private exponent as key.

---
 rtl/crypto_rsa_pkg.sv | 18 +
 rtl/crypto_rsa_modmul.sv | 79 +++++++
 rtl/crypto_rsa.sv | 190 +++++++++++++++++++
 tb/tb_crypto_rsa.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/crypto_rsa_pkg.sv
// rtl/crypto_rsa_pkg.sv - shared types and constants for the RSA modular-exponentiation engine
//
// Contents:
//   DEFAULT_WIDTH : default operand width for key, n, plaintext and ciphertext
//   state_t       : top-level sequencer states
package crypto_rsa_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REDUCE = 3'd1,
        MUL    = 3'd2,
        SQR    = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/crypto_rsa_modmul.sv
// rtl/crypto_rsa_modmul.sv - interleaved shift-add modular multiplier, one multiplier bit per cycle
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset
//   start  : capture a/b/n and clear the accumulator (no step is taken on this edge)
//   a      : multiplier, consumed MSB first
//   b      : multiplicand, must be < n (b=1 is also allowed for plain reduction)
//   n      : modulus
//   busy   : a step is taken on the next edge
//   done   : the step taken on the next edge is the last one; r is the final product
//   r      : combinational result of the step in progress (a*b mod n when done=1)
//
// The product is offered combinationally during the final step so the sequencer can
// capture it and restart the multiplier on the same edge, with no idle cycle between
// multiplications.
import crypto_rsa_pkg::*;

module crypto_rsa_modmul #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH+1:0] acc;
    logic [CW-1:0]    cnt;

    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] sub1;
    logic [WIDTH+1:0] step_r;
    logic [WIDTH+1:0] n_ext;

    // acc < n and b < n keep 2*acc + b below 3n, so two conditional subtractions
    // always bring the accumulator back below n, and WIDTH+2 bits never overflow.
    always_comb begin
        n_ext  = {2'b00, n_r};
        sum    = (acc << 1) + (a_sh[WIDTH-1] ? {2'b00, b_r} : '0);
        sub1   = (sum  >= n_ext) ? (sum  - n_ext) : sum;
        step_r = (sub1 >= n_ext) ? (sub1 - n_ext) : sub1;
    end

    assign busy = (cnt != '0);
    assign done = (cnt == CW'(1));
    assign r    = step_r[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_sh <= '0;
            b_r  <= '0;
            n_r  <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (start) begin
            a_sh <= a;
            b_r  <= b;
            n_r  <= n;
            acc  <= '0;
            cnt  <= CW'(WIDTH);
        end else if (busy) begin
            a_sh <= a_sh << 1;
            acc  <= step_r;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/crypto_rsa.sv
// rtl/crypto_rsa.sv - constant-time RSA engine: ciphertext = plaintext^key mod n
//
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous active-low reset
//   key        : exponent, captured on load
//   n          : modulus, captured on load
//   plaintext  : base, captured on load
//   load       : capture key/n/plaintext (only while ready)
//   encrypt    : start a run from the captured operands (only while ready and not loading)
//   ready      : 1 = idle with ciphertext valid, 0 = busy
//   ciphertext : result of the last completed run
//
// Right-to-left binary exponentiation: for each key bit (LSB first) one MUL pass and
// one SQR pass, each a full WIDTH-cycle modular multiply, regardless of the key bit.
import crypto_rsa_pkg::*;

module crypto_rsa #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] plaintext,
    input  logic             load,
    input  logic             encrypt,
    output logic             ready,
    output logic [WIDTH-1:0] ciphertext
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t state, next_state;

    logic [WIDTH-1:0] key_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] pt_r;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] result;
    logic [IW-1:0]    bit_idx;
    logic             kick;

    logic             mm_start;
    logic [WIDTH-1:0] mm_a;
    logic [WIDTH-1:0] mm_b;
    logic             mm_busy;
    logic             mm_done;
    logic [WIDTH-1:0] mm_r;

    logic [WIDTH-1:0] one_mod_n;
    logic             last_bit;

    // 1 mod n: zero for n==0 and n==1, which forces every later product to zero.
    assign one_mod_n = {{(WIDTH-1){1'b0}}, (n_r > WIDTH'(1))};
    assign last_bit  = (bit_idx == IW'(WIDTH - 1));

    crypto_rsa_modmul #(
        .WIDTH (WIDTH)
    ) u_modmul (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .n     (n_r),
        .busy  (mm_busy),
        .done  (mm_done),
        .r     (mm_r)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Each phase restarts the multiplier on the edge where the previous one finishes,
    // feeding it the freshly produced product where the next phase depends on it.
    always_comb begin
        next_state = state;
        mm_start   = 1'b0;
        mm_a       = '0;
        mm_b       = '0;
        case (state)
            IDLE: begin
                if (encrypt && !load) begin
                    next_state = REDUCE;
                end
            end
            REDUCE: begin
                if (kick) begin
                    mm_start = 1'b1;
                    mm_a     = pt_r;
                    mm_b     = WIDTH'(1);
                end else if (mm_done) begin
                    next_state = MUL;
                    mm_start   = 1'b1;
                    mm_a       = one_mod_n;
                    mm_b       = mm_r;
                end
            end
            MUL: begin
                if (mm_done) begin
                    next_state = SQR;
                    mm_start   = 1'b1;
                    mm_a       = base;
                    mm_b       = base;
                end
            end
            SQR: begin
                if (mm_done) begin
                    if (last_bit) begin
                        next_state = DONE;
                    end else begin
                        next_state = MUL;
                        mm_start   = 1'b1;
                        mm_a       = result;
                        mm_b       = mm_r;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_r      <= '0;
            n_r        <= '0;
            pt_r       <= '0;
            base       <= '0;
            result     <= '0;
            bit_idx    <= '0;
            kick       <= 1'b0;
            ready      <= 1'b1;
            ciphertext <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        key_r <= key;
                        n_r   <= n;
                        pt_r  <= plaintext;
                    end else if (encrypt) begin
                        kick    <= 1'b1;
                        ready   <= 1'b0;
                        bit_idx <= '0;
                    end
                end
                REDUCE: begin
                    kick <= 1'b0;
                    if (!kick && mm_done) begin
                        base   <= mm_r;
                        result <= one_mod_n;
                    end
                end
                MUL: begin
                    // The multiply always runs; only the write-back depends on the key bit.
                    if (mm_done && key_r[bit_idx]) begin
                        result <= mm_r;
                    end
                end
                SQR: begin
                    if (mm_done) begin
                        base <= mm_r;
                        if (!last_bit) begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                DONE: begin
                    ciphertext <= result;
                    ready      <= 1'b1;
                end
                default: begin
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_rsa.sv
// tb/tb_crypto_rsa.sv - directed self-checking bench for crypto_rsa
module tb_crypto_rsa;

    localparam int W = 32;
    localparam int LAT = W * (2 * W + 1) + 2;

    logic         clk;
    logic         reset;
    logic [W-1:0] key;
    logic [W-1:0] n;
    logic [W-1:0] plaintext;
    logic         load;
    logic         encrypt;
    logic         ready;
    logic [W-1:0] ciphertext;

    int checks;
    int fails;
    int lat;

    crypto_rsa #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .key        (key),
        .n          (n),
        .plaintext  (plaintext),
        .load       (load),
        .encrypt    (encrypt),
        .ready      (ready),
        .ciphertext (ciphertext)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] k, input logic [W-1:0] p, input logic [W-1:0] m);
        key       = k;
        plaintext = p;
        n         = m;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    // Pulses encrypt for one edge (edge 0) and counts edges until ready returns.
    task automatic run_enc(output int cycles);
        encrypt = 1'b1;
        tick();
        encrypt = 1'b0;
        check("ready_low_after_start", {{(W-1){1'b0}}, ready}, '0);
        cycles = 0;
        while (ready !== 1'b1 && cycles < LAT + 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic op(input string tag, input logic [W-1:0] k, input logic [W-1:0] p,
                      input logic [W-1:0] m, input logic [W-1:0] exp);
        do_load(k, p, m);
        run_enc(lat);
        check({tag, "_latency"}, W'(lat), W'(LAT));
        check(tag, ciphertext, exp);
    endtask

    function automatic logic [W-1:0] sw_modexp(input logic [W-1:0] k, input logic [W-1:0] p,
                                               input logic [W-1:0] m);
        longint unsigned r, b, mm;
        mm = {32'd0, m};
        r  = 64'd1 % mm;
        b  = {32'd0, p} % mm;
        for (int i = 0; i < W; i++) begin
            if (k[i]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return r[W-1:0];
    endfunction

    initial begin
        checks    = 0;
        fails     = 0;
        reset     = 1'b0;
        key       = '0;
        n         = '0;
        plaintext = '0;
        load      = 1'b0;
        encrypt   = 1'b0;
        tick();
        check("reset_ready", {{(W-1){1'b0}}, ready}, W'(1));
        check("reset_ciphertext", ciphertext, '0);
        reset = 1'b1;

        // Basic: load, then encrypt two cycles later.
        do_load(32'd7, 32'd9, 32'd143);
        check("load_keeps_ciphertext", ciphertext, '0);
        check("load_keeps_ready", {{(W-1){1'b0}}, ready}, W'(1));
        tick();
        run_enc(lat);
        check("basic_latency", W'(lat), W'(LAT));
        check("basic", ciphertext, 32'd48);

        // Round trips.
        op("rt_143_dec", 32'd103, 32'd48, 32'd143, 32'd9);
        op("rt_3233_enc", 32'd17, 32'd65, 32'd3233, 32'd2790);
        op("rt_3233_dec", 32'd2753, 32'd2790, 32'd3233, 32'd65);

        // Edge operands.
        op("key_zero", 32'd0, 32'd5, 32'd143, 32'd1);
        op("pt_ge_n", 32'd1, 32'd200, 32'd143, 32'd57);
        op("n_one", 32'd5, 32'd7, 32'd1, 32'd0);
        op("pt_zero", 32'd5, 32'd0, 32'd143, 32'd0);
        op("wide", 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB,
           sw_modexp(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFB));

        // Mid-run load/encrypt are ignored.
        do_load(32'd7, 32'd9, 32'd143);
        encrypt = 1'b1;
        tick();
        encrypt = 1'b0;
        lat = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            lat++;
        end
        key       = 32'd1;
        plaintext = 32'd5;
        n         = 32'd7;
        load      = 1'b1;
        encrypt   = 1'b1;
        tick();
        lat++;
        load      = 1'b0;
        encrypt   = 1'b0;
        while (ready !== 1'b1 && lat < LAT + 200) begin
            tick();
            lat++;
        end
        check("midrun_latency", W'(lat), W'(LAT));
        check("midrun_result", ciphertext, 32'd48);
        run_enc(lat);
        check("reencrypt_old_operands", ciphertext, 32'd48);

        // load and encrypt together: capture only, no start.
        key       = 32'd0;
        plaintext = 32'd5;
        n         = 32'd143;
        load      = 1'b1;
        encrypt   = 1'b1;
        tick();
        load      = 1'b0;
        encrypt   = 1'b0;
        check("load_enc_ready_1", {{(W-1){1'b0}}, ready}, W'(1));
        tick();
        tick();
        check("load_enc_ready_3", {{(W-1){1'b0}}, ready}, W'(1));
        check("load_enc_ciphertext", ciphertext, 32'd48);
        run_enc(lat);
        check("load_enc_new_operands", ciphertext, 32'd1);

        // Reset 500 cycles into a run.
        do_load(32'd17, 32'd65, 32'd3233);
        encrypt = 1'b1;
        tick();
        encrypt = 1'b0;
        for (int c = 0; c < 500; c++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset_ready", {{(W-1){1'b0}}, ready}, W'(1));
        check("midreset_ciphertext", ciphertext, '0);
        tick();
        check("midreset_stays_idle", {{(W-1){1'b0}}, ready}, W'(1));
        op("after_reset", 32'd7, 32'd9, 32'd143, 32'd48);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
